// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read-side stream controller.
package fifo_rd_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;
    typedef logic [1:0] credit_t;

    // Free skid slots once in-flight data lands, counting the slot a pop frees this cycle.
    function automatic credit_t calc_credit(input occ_t occ, input logic inflight, input logic pop);
        logic [2:0] c;
        c = 3'(SKID_DEPTH) - {1'b0, occ} - {2'b0, inflight} + {2'b0, pop};
        return credit_t'(c);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order data buffer that absorbs the FIFO's one-cycle read latency.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = 5
) (
    input  logic              clk_i,
    input  logic              s_rst_i,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output occ_t              occ
);

    logic [DATA_W-1:0] mem_q [SKID_DEPTH];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    occ_t              occ_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            // NOTE: only two register entries, so clearing them is cheap and keeps the head at 0 after reset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            occ_q    <= occ_q + occ_t'(push) - occ_t'(pop);
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occ       = occ_q;

    // The credit rule upstream guarantees a landing slot for every issued read.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (s_rst_i)
        !(push && occ_q == occ_t'(SKID_DEPTH)));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (s_rst_i)
        !(pop && occ_q == '0));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port to valid/ready stream adapter with a 2-entry skid buffer.
// Optional delivered-word counter on word_cnt_o when FIFO_RD_WORD_CNT_EN is defined.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              s_rst_i,
    output logic              fifo_rd_req_o,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    input  logic              fifo_empty_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
`ifdef FIFO_RD_WORD_CNT_EN
    ,
    output logic [CNT_W-1:0]  word_cnt_o
`endif
);

    logic    inflight_q;
    logic    pop;
    credit_t credit;
    occ_t    occ;

    assign pop    = out_valid_o && out_ready_i;
    assign credit = calc_credit(occ, inflight_q, pop);

    assign fifo_rd_req_o = !fifo_empty_i && (credit != '0) && !s_rst_i;

    // A request accepted this cycle means its data is on fifo_rd_data_i next cycle.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_req_o;
        end
    end

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i     (clk_i),
        .s_rst_i   (s_rst_i),
        .push      (inflight_q),
        .push_data (fifo_rd_data_i),
        .pop       (pop),
        .head_data (out_data_o),
        .occ       (occ)
    );

    assign out_valid_o = (occ != '0);

`ifdef FIFO_RD_WORD_CNT_EN
    logic [CNT_W-1:0] word_cnt_q;

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            word_cnt_q <= '0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream against a small registered-read FIFO model.
module tb_fifo_rd_stream;

    localparam int DATA_W = 5;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              s_rst_i;
    logic              fifo_rd_req_o;
    logic [DATA_W-1:0] fifo_rd_data_i;
    logic              fifo_empty_i;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;
`ifdef FIFO_RD_WORD_CNT_EN
    logic [CNT_W-1:0]  word_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    fifo_rd_stream #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .s_rst_i        (s_rst_i),
        .fifo_rd_req_o  (fifo_rd_req_o),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_ready_i    (out_ready_i)
`ifdef FIFO_RD_WORD_CNT_EN
        ,
        .word_cnt_o     (word_cnt_o)
`endif
    );

    // FIFO model: registered read port, shares the DUT reset.
    logic [DATA_W-1:0] fifo_mem [64];
    int wr_idx = 0;
    int rd_idx = 0;

    assign fifo_empty_i = (rd_idx == wr_idx);

    always @(posedge clk_i) begin
        if (s_rst_i) begin
            rd_idx         <= wr_idx;
            fifo_rd_data_i <= '0;
        end else if (fifo_rd_req_o && !fifo_empty_i) begin
            fifo_rd_data_i <= fifo_mem[rd_idx % 64];
            rd_idx         <= rd_idx + 1;
        end
    end

    int delivered = 0;
    always @(posedge clk_i) begin
        if (s_rst_i) delivered <= 0;
        else if (out_valid_o && out_ready_i) delivered <= delivered + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        fifo_mem[wr_idx % 64] = d;
        wr_idx = wr_idx + 1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic expect_word(input string tag, input logic [DATA_W-1:0] exp);
        bit seen;
        seen = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid_o) begin
                seen = 1'b1;
                check(tag, 32'(out_data_o), 32'(exp));
            end
            tick();
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    function automatic logic [DATA_W-1:0] rnd_word(input int k);
        return DATA_W'(k * 7 + 3);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        int pushed;
        int got;

        s_rst_i     = 1'b1;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_rd_req", 32'(fifo_rd_req_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", 32'(out_data_o), 32'd0);
        s_rst_i = 1'b0;
        #1;

        // Idle with an empty FIFO.
        for (int c = 0; c < 20; c++) begin
            check("idle_rd_req", 32'(fifo_rd_req_o), 32'd0);
            check("idle_valid", 32'(out_valid_o), 32'd0);
            tick();
        end
`ifdef FIFO_RD_WORD_CNT_EN
        check("idle_cnt", 32'(word_cnt_o), 32'd0);
`endif

        // Burst 1..8 with the consumer always ready.
        out_ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) push_word(DATA_W'(k));
        #1;
        for (int c = 0; c < 12; c++) begin
            check("burst_rd_req", 32'(fifo_rd_req_o), 32'(c <= 7));
            check("burst_valid", 32'(out_valid_o), 32'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) check("burst_data", 32'(out_data_o), 32'(c - 1));
            tick();
        end
`ifdef FIFO_RD_WORD_CNT_EN
        check("burst_cnt", 32'(word_cnt_o), 32'd8);
`endif

        // Stall for 10 cycles, then drain with no gaps.
        out_ready_i = 1'b0;
        for (int k = 1; k <= 8; k++) push_word(DATA_W'(k));
        #1;
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            if (fifo_rd_req_o) reqs++;
            if (c >= 2) begin
                check("stall_valid", 32'(out_valid_o), 32'd1);
                check("stall_data", 32'(out_data_o), 32'd1);
            end
            tick();
        end
        check("stall_reqs", 32'(reqs), 32'd2);
        out_ready_i = 1'b1;
        #1;
        for (int k = 1; k <= 8; k++) begin
            check("drain_valid", 32'(out_valid_o), 32'd1);
            check("drain_data", 32'(out_data_o), 32'(k));
            tick();
        end
        check("drain_done_valid", 32'(out_valid_o), 32'd0);

        // Random backpressure and random FIFO fill, in-order scoreboard.
        pushed = 0;
        got    = 0;
        for (int c = 0; c < 3000 && got < 60; c++) begin
            if (pushed < 60 && $urandom_range(1) == 1) begin
                push_word(rnd_word(pushed));
                pushed++;
            end
            out_ready_i = 1'($urandom_range(1));
            #1;
            if (out_valid_o && out_ready_i) begin
                check("rand_data", 32'(out_data_o), 32'(rnd_word(got)));
                got++;
            end
            tick();
        end
        check("rand_count", 32'(got), 32'd60);

        // Reset while the buffer is full and the FIFO still holds words.
        out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) push_word(DATA_W'(8'h11 + k));
        #1;
        repeat (3) tick();
        check("prerst_valid", 32'(out_valid_o), 32'd1);
        check("prerst_data", 32'(out_data_o), 32'h11);
        s_rst_i     = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check("inrst_rd_req", 32'(fifo_rd_req_o), 32'd0);
        tick();
        s_rst_i     = 1'b0;
        out_ready_i = 1'b0;
        #1;
        check("postrst_valid", 32'(out_valid_o), 32'd0);
        check("postrst_data", 32'(out_data_o), 32'd0);
        check("postrst_rd_req", 32'(fifo_rd_req_o), 32'd0);
`ifdef FIFO_RD_WORD_CNT_EN
        check("postrst_cnt", 32'(word_cnt_o), 32'd0);
`endif
        push_word(5'h1A);
        push_word(5'h05);
        #1;
        expect_word("postrst_w0", 5'h1A);
        expect_word("postrst_w1", 5'h05);

        // Fifteen more words: 17 since reset, so a 4-bit counter reads 1.
        for (int k = 0; k < 15; k++) push_word(DATA_W'(k + 1));
        #1;
        for (int k = 0; k < 15; k++) expect_word("wrap_word", DATA_W'(k + 1));
        check("wrap_delivered", 32'(delivered), 32'd17);
`ifdef FIFO_RD_WORD_CNT_EN
        check("wrap_cnt", 32'(word_cnt_o), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
